pccm_cpu_agent: RTL and testbench

- Per-core endpoint of the PCCM sync/halt/continue protocol; one instance per soft core, four in the system.
- Converts core-side barrier and halt requests into level `cpu_sync`/`cpu_halt` toward the controller.
- Gates core execution until the controller's Continue arrives, and honours controller `int_reset`/`int_init`.
- Adds a barrier counter and a sticky sync-timeout error for NIOS diagnostics.

---
 rtl/pccm_pkg.sv | 25 ++
 rtl/pccm_cpu_agent_if.sv | 27 ++
 rtl/pccm_timeout_ctr.sv | 27 ++
 rtl/pccm_cpu_agent.sv | 88 ++++++++
 tb/tb_pccm_cpu_agent.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pccm_pkg.sv
// Shared PCCM definitions: per-core agent state encoding and the NIOS
// control/response codes used by both the agents and the controller.
package pccm_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    ARM       = 3'd1,
    RUN       = 3'd2,
    SYNC_WAIT = 3'd3,
    REARM     = 3'd4,
    HALTED    = 3'd5,
    ERROR     = 3'd6
  } agent_state_t;

  localparam logic [3:0] CTRL_NOP     = 4'h0;
  localparam logic [3:0] CTRL_START   = 4'h1;
  localparam logic [3:0] CTRL_INIT    = 4'h2;
  localparam logic [3:0] CTRL_RESET   = 4'h3;

  localparam logic [3:0] RESP_IDLE    = 4'h0;
  localparam logic [3:0] RESP_RUNNING = 4'h1;
  localparam logic [3:0] RESP_DONE    = 4'h2;
  localparam logic [3:0] RESP_ERROR   = 4'h3;

endpackage

// File: rtl/pccm_cpu_agent_if.sv
// Controller/core-facing signal bundle of one PCCM CPU agent.
interface pccm_cpu_agent_if #(
  parameter int unsigned CNT_W = 16
);
  logic             int_reset;
  logic             int_init;
  logic             cpu_Continue;
  logic             core_sync_req;
  logic             core_halt_req;
  logic             cpu_sync;
  logic             cpu_halt;
  logic             core_run;
  logic             core_sync_ack;
  logic [CNT_W-1:0] barrier_cnt;
  logic             sync_err;
  logic [2:0]       agent_state;

  modport master (
    output int_reset, int_init, cpu_Continue, core_sync_req, core_halt_req,
    input  cpu_sync, cpu_halt, core_run, core_sync_ack, barrier_cnt, sync_err, agent_state
  );

  modport slave (
    input  int_reset, int_init, cpu_Continue, core_sync_req, core_halt_req,
    output cpu_sync, cpu_halt, core_run, core_sync_ack, barrier_cnt, sync_err, agent_state
  );
endinterface

// File: rtl/pccm_timeout_ctr.sv
// Barrier-wait timeout counter: expire is high while the count sits on LIMIT-1.
// LIMIT = 0 disables expiry.
module pccm_timeout_ctr #(
  parameter int unsigned LIMIT = 4096,
  parameter int unsigned W     = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [W-1:0] LAST    = W'(LIMIT - 1);
  localparam bit           ENABLED = (LIMIT != 0);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  always_comb begin
    expire = ENABLED && (count == LAST);
  end
endmodule

// File: rtl/pccm_cpu_agent.sv
// Per-core PCCM agent: turns core barrier/halt requests into cpu_sync/cpu_halt
// levels and gates core_run on the controller's Continue.
module pccm_cpu_agent
  import pccm_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 4096,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  pccm_cpu_agent_if.slave   bus
);
  agent_state_t     state, state_n;
  logic             pend, pend_n;
  logic             sync_q, halt_q, run_q, ack_q, err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             release_bar, init_hit, expire, tmo_clr;

  // Counter is zero on the first SYNC_WAIT cycle and cleared on any exit.
  assign tmo_clr = bus.int_reset | (state != SYNC_WAIT) | (state_n != SYNC_WAIT);

  pccm_timeout_ctr #(.LIMIT(SYNC_TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (reset),
    .clr    (tmo_clr),
    .en     (state == SYNC_WAIT),
    .expire (expire)
  );

  always_comb begin
    state_n  = state;
    pend_n   = pend;
    init_hit = bus.int_init && (state inside {HOLD, ARM, HALTED, ERROR});
    if (init_hit) begin
      state_n = HOLD;
    end else begin
      unique case (state)
        HOLD:      if (!bus.cpu_Continue) state_n = ARM;
        ARM:       if (bus.cpu_Continue)  state_n = RUN;
        RUN: begin
          if (bus.core_halt_req)               state_n = HALTED;
          else if (bus.core_sync_req || pend)  state_n = SYNC_WAIT;
        end
        SYNC_WAIT: begin
          if (bus.cpu_Continue) state_n = REARM;
          else if (expire)      state_n = ERROR;
        end
        REARM: begin
          // Ignore the request still held during the ack cycle; it was just serviced.
          pend_n = pend | (bus.core_sync_req & ~ack_q);
          if (bus.core_halt_req)      state_n = HALTED;
          else if (!bus.cpu_Continue) state_n = RUN;
        end
        default: state_n = state;
      endcase
    end
    if (!(state_n inside {RUN, REARM})) pend_n = 1'b0;
    release_bar = (state == SYNC_WAIT) && (state_n == REARM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HOLD; pend <= 1'b0; cnt_q <= '0; err_q <= 1'b0;
      sync_q <= 1'b0; halt_q <= 1'b0; run_q <= 1'b0; ack_q <= 1'b0;
    end else if (bus.int_reset) begin
      state <= HOLD; pend <= 1'b0; cnt_q <= '0; err_q <= 1'b0;
      sync_q <= 1'b0; halt_q <= 1'b0; run_q <= 1'b0; ack_q <= 1'b0;
    end else begin
      state  <= state_n;
      pend   <= pend_n;
      sync_q <= (state_n == SYNC_WAIT);
      halt_q <= (state_n inside {HALTED, ERROR});
      run_q  <= (state_n inside {RUN, REARM});
      ack_q  <= release_bar;
      err_q  <= err_q | (state_n == ERROR);
      if (init_hit)         cnt_q <= '0;
      else if (release_bar) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.cpu_sync      = sync_q;
  assign bus.cpu_halt      = halt_q;
  assign bus.core_run      = run_q;
  assign bus.core_sync_ack = ack_q;
  assign bus.barrier_cnt   = cnt_q;
  assign bus.sync_err      = err_q;
  assign bus.agent_state   = state;
endmodule

// File: tb/tb_pccm_cpu_agent.sv
// Bench for pccm_cpu_agent: directed protocol steps on two parameterisations,
// then randomized core/controller traffic checked against a behavioural model.
module tb_pccm_cpu_agent;
  import pccm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  pccm_cpu_agent_if #(.CNT_W(2))  bus_a ();
  pccm_cpu_agent_if #(.CNT_W(16)) bus_b ();

  pccm_cpu_agent #(.SYNC_TIMEOUT(8), .CNT_W(2)) u_a (
    .clk(clk), .reset(rst_a), .bus(bus_a.slave)
  );
  pccm_cpu_agent #(.SYNC_TIMEOUT(4), .CNT_W(16)) u_b (
    .clk(clk), .reset(rst_b), .bus(bus_b.slave)
  );

  // Reference model of agent A (timeout 8, counter modulo 4)
  agent_state_t m_st;
  int           m_wait, m_cnt;
  bit           m_ack, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input bit use_b, input string tag, input agent_state_t st,
                         input bit sy, input bit ha, input bit ru, input bit ak,
                         input int cnt, input bit er);
    logic [2:0]  o_st;
    logic        o_sy, o_ha, o_ru, o_ak, o_er;
    logic [15:0] o_cnt;
    if (use_b) begin
      o_st = bus_b.agent_state; o_sy = bus_b.cpu_sync; o_ha = bus_b.cpu_halt;
      o_ru = bus_b.core_run; o_ak = bus_b.core_sync_ack; o_er = bus_b.sync_err;
      o_cnt = bus_b.barrier_cnt;
    end else begin
      o_st = bus_a.agent_state; o_sy = bus_a.cpu_sync; o_ha = bus_a.cpu_halt;
      o_ru = bus_a.core_run; o_ak = bus_a.core_sync_ack; o_er = bus_a.sync_err;
      o_cnt = 16'(bus_a.barrier_cnt);
    end
    chk({tag, ".state"},    32'(o_st), 32'(st));
    chk({tag, ".cpu_sync"}, 32'(o_sy), 32'(sy));
    chk({tag, ".cpu_halt"}, 32'(o_ha), 32'(ha));
    chk({tag, ".core_run"}, 32'(o_ru), 32'(ru));
    chk({tag, ".ack"},      32'(o_ak), 32'(ak));
    chk({tag, ".cnt"},      32'(o_cnt), cnt);
    chk({tag, ".sync_err"}, 32'(o_er), 32'(er));
    chk({tag, ".sync_and_halt"}, 32'(o_sy & o_ha), 32'd0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic up_a();
    bus_a.cpu_Continue = 1'b0; cyc(1);
    bus_a.cpu_Continue = 1'b1; cyc(1);
    bus_a.cpu_Continue = 1'b0;
  endtask

  task automatic up_b();
    bus_b.cpu_Continue = 1'b0; cyc(1);
    bus_b.cpu_Continue = 1'b1; cyc(1);
    bus_b.cpu_Continue = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit sr, input bit hr, input bit ir, input bit ii);
    m_ack = 1'b0;
    if (ir) begin
      m_st = HOLD; m_cnt = 0; m_err = 1'b0; m_wait = 0;
    end else if (ii && (m_st == HOLD || m_st == ARM || m_st == HALTED || m_st == ERROR)) begin
      m_st = HOLD; m_cnt = 0;
    end else begin
      case (m_st)
        HOLD:   if (!c) m_st = ARM;
        ARM:    if (c)  m_st = RUN;
        RUN: begin
          if (hr) m_st = HALTED;
          else if (sr) begin m_st = SYNC_WAIT; m_wait = 0; end
        end
        SYNC_WAIT: begin
          m_wait++;
          if (c) begin m_st = REARM; m_ack = 1'b1; m_cnt = (m_cnt + 1) % 4; end
          else if (m_wait == 8) begin m_st = ERROR; m_err = 1'b1; end
        end
        REARM: begin
          if (hr) m_st = HALTED;
          else if (!c) m_st = RUN;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    {bus_a.int_reset, bus_a.int_init, bus_a.cpu_Continue, bus_a.core_sync_req, bus_a.core_halt_req} = '0;
    {bus_b.int_reset, bus_b.int_init, bus_b.cpu_Continue, bus_b.core_sync_req, bus_b.core_halt_req} = '0;
    cyc(2);
    chk_dut(0, "rst", HOLD, 0, 0, 0, 0, 0, 0);

    // Start-up: HOLD -> ARM on Continue low, ARM -> RUN on the start pulse
    rst_a = 1'b0; cyc(1);
    chk_dut(0, "t1.arm", ARM, 0, 0, 0, 0, 0, 0);
    cyc(2);
    bus_a.cpu_Continue = 1'b1; cyc(1);
    chk_dut(0, "t1.run", RUN, 0, 0, 1, 0, 0, 0);
    bus_a.cpu_Continue = 1'b0;

    // Barrier with Continue held 4 cycles; new request must wait for Continue low
    bus_a.core_sync_req = 1'b1; cyc(1);
    chk_dut(0, "t2.sync", SYNC_WAIT, 1, 0, 0, 0, 0, 0);
    bus_a.cpu_Continue = 1'b1; cyc(1);
    chk_dut(0, "t2.ack", REARM, 0, 0, 1, 1, 1, 0);
    bus_a.core_sync_req = 1'b0; cyc(1);
    chk_dut(0, "t2.rearm1", REARM, 0, 0, 1, 0, 1, 0);
    bus_a.core_sync_req = 1'b1; cyc(1);
    chk_dut(0, "t2.rearm2", REARM, 0, 0, 1, 0, 1, 0);
    cyc(1);
    chk_dut(0, "t2.rearm3", REARM, 0, 0, 1, 0, 1, 0);
    bus_a.cpu_Continue = 1'b0; cyc(1);
    chk_dut(0, "t2.run", RUN, 0, 0, 1, 0, 1, 0);
    cyc(1);
    chk_dut(0, "t2.held", SYNC_WAIT, 1, 0, 0, 0, 1, 0);
    bus_a.cpu_Continue = 1'b1; cyc(1);
    chk_dut(0, "t2.ack2", REARM, 0, 0, 1, 1, 2, 0);
    bus_a.core_sync_req = 1'b0; bus_a.cpu_Continue = 1'b0; cyc(1);
    chk_dut(0, "t2.back", RUN, 0, 0, 1, 0, 2, 0);

    // Halt beats sync in the same cycle; HALTED is terminal until init
    bus_a.core_sync_req = 1'b1; bus_a.core_halt_req = 1'b1; cyc(1);
    chk_dut(0, "t4.halt", HALTED, 0, 1, 0, 0, 2, 0);
    bus_a.core_sync_req = 1'b0; bus_a.core_halt_req = 1'b0; cyc(1);
    chk_dut(0, "t4.stay", HALTED, 0, 1, 0, 0, 2, 0);
    bus_a.int_init = 1'b1; cyc(1);
    chk_dut(0, "t4.init", HOLD, 0, 0, 0, 0, 0, 0);
    bus_a.int_init = 1'b0;

    // Counter wrap at 2 bits, then async reset in the middle of a barrier wait
    up_a();
    for (int i = 0; i < 5; i++) begin
      bus_a.core_sync_req = 1'b1; cyc(1);
      bus_a.cpu_Continue = 1'b1; cyc(1);
      bus_a.core_sync_req = 1'b0; bus_a.cpu_Continue = 1'b0; cyc(1);
      chk("t5.cnt", 32'(bus_a.barrier_cnt), (i + 1) % 4);
    end
    bus_a.core_sync_req = 1'b1; cyc(3);
    chk_dut(0, "t5.wait", SYNC_WAIT, 1, 0, 0, 0, 1, 0);
    #2 rst_a = 1'b1;
    #1 chk_dut(0, "t5.async", HOLD, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_a = 1'b0; bus_a.core_sync_req = 1'b0;

    // Timeout after 8 wait cycles; int_init keeps the error, int_reset clears it
    up_a();
    bus_a.core_sync_req = 1'b1; cyc(1);
    chk_dut(0, "t3.w0", SYNC_WAIT, 1, 0, 0, 0, 0, 0);
    cyc(7);
    chk_dut(0, "t3.w7", SYNC_WAIT, 1, 0, 0, 0, 0, 0);
    cyc(1);
    chk_dut(0, "t3.err", ERROR, 0, 1, 0, 0, 0, 1);
    bus_a.core_sync_req = 1'b0; bus_a.int_init = 1'b1; cyc(1);
    chk_dut(0, "t3.init", HOLD, 0, 0, 0, 0, 0, 1);
    bus_a.int_init = 1'b0; bus_a.int_reset = 1'b1; cyc(1);
    chk_dut(0, "t3.irst", HOLD, 0, 0, 0, 0, 0, 0);
    bus_a.int_reset = 1'b0;

    // Timeout 4: Continue on the expiry cycle wins; without it the next wait errors
    rst_b = 1'b0;
    chk_dut(1, "t6.rst", HOLD, 0, 0, 0, 0, 0, 0);
    up_b();
    bus_b.core_sync_req = 1'b1; cyc(1);
    cyc(3);
    chk_dut(1, "t6.w3", SYNC_WAIT, 1, 0, 0, 0, 0, 0);
    bus_b.cpu_Continue = 1'b1; cyc(1);
    chk_dut(1, "t6.win", REARM, 0, 0, 1, 1, 1, 0);
    bus_b.core_sync_req = 1'b0; bus_b.cpu_Continue = 1'b0; cyc(1);
    chk_dut(1, "t6.run", RUN, 0, 0, 1, 0, 1, 0);
    bus_b.core_sync_req = 1'b1; cyc(4);
    chk_dut(1, "t6.w3b", SYNC_WAIT, 1, 0, 0, 0, 1, 0);
    cyc(1);
    chk_dut(1, "t6.err", ERROR, 0, 1, 0, 0, 1, 1);

    // Randomized traffic on agent A against the model
    rst_a = 1'b1;
    {bus_a.int_reset, bus_a.int_init, bus_a.cpu_Continue, bus_a.core_sync_req, bus_a.core_halt_req} = '0;
    m_st = HOLD; m_cnt = 0; m_err = 1'b0; m_wait = 0; m_ack = 1'b0;
    cyc(1);
    rst_a = 1'b0;
    for (int i = 0; i < 800; i++) begin
      bus_a.int_reset     = ($urandom_range(63) == 0);
      bus_a.int_init      = ($urandom_range(31) == 0);
      bus_a.core_halt_req = ($urandom_range(39) == 0);
      if ($urandom_range(2) == 0) bus_a.cpu_Continue = ~bus_a.cpu_Continue;
      if (m_ack) bus_a.core_sync_req = 1'b0;
      else if (!bus_a.core_sync_req && $urandom_range(3) == 0) bus_a.core_sync_req = 1'b1;
      @(posedge clk);
      model_step(bus_a.cpu_Continue, bus_a.core_sync_req, bus_a.core_halt_req,
                 bus_a.int_reset, bus_a.int_init);
      @(negedge clk);
      chk_dut(0, "rnd", m_st, m_st == SYNC_WAIT, m_st == HALTED || m_st == ERROR,
              m_st == RUN || m_st == REARM, m_ack, m_cnt, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
